controlador_interrupcoes: RTL and testbench

Parametrised interrupt controller for the single-cycle core. It replaces the fixed halt/clock interrupt pair with NUM_SOURCES external request lines plus an internal reloadable timer, a mask register, fixed-priority selection, and a saved return PC. It also provides a cause register that the OS reads and clears. It sits beside the PC module: it watches the retiring PC, redirects fetch to a vector address, and feeds the cause and return PC to the register-file write mux.

---
 rtl/controlador_interrupcoes.sv | 138 +++++++++++++
 tb/tb_controlador_interrupcoes.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_interrupcoes.sv
// Interrupt controller: edge-detected external requests plus a reloadable timer,
// masked fixed-priority selection, saved return PC and a read-and-clear cause word.
module controlador_interrupcoes #(
  parameter int unsigned NUM_SOURCES = 4,
  parameter int unsigned ADDR_WIDTH  = 13,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TIMER_WIDTH = 16,
  parameter int unsigned VECTOR_BASE = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    avanca,
  input  logic [NUM_SOURCES-1:0]  irq_in,
  input  logic                    mask_we,
  input  logic [NUM_SOURCES:0]    mask_data,
  input  logic                    timer_set,
  input  logic [TIMER_WIDTH-1:0]  timer_value,
  input  logic                    timer_reload,
  input  logic [ADDR_WIDTH-1:0]   pc_next,
  input  logic                    ack_cause,
  input  logic                    iret,
  output logic                    int_take,
  output logic [ADDR_WIDTH-1:0]   int_vector,
  output logic [ADDR_WIDTH-1:0]   pc_salvo,
  output logic [DATA_WIDTH-1:0]   causa,
  output logic                    em_servico,
  output logic [NUM_SOURCES:0]    pendentes
);

  localparam int unsigned NP    = NUM_SOURCES + 1;
  localparam int unsigned IDX_W = $clog2(NP + 1);

  typedef enum logic {OCIOSO = 1'b0, SERVICO = 1'b1} estado_t;

  estado_t                 estado_q, estado_d;
  logic [NUM_SOURCES-1:0]  irq_sync_q, irq_sync_d;
  logic [NUM_SOURCES-1:0]  irq_prev_q, irq_prev_d;
  logic [NUM_SOURCES:0]    mask_q, mask_d;
  logic [NUM_SOURCES:0]    pend_q, pend_d;
  logic [NUM_SOURCES:0]    eligible;
  logic [TIMER_WIDTH-1:0]  count_q, count_d;
  logic [TIMER_WIDTH-1:0]  reload_val_q, reload_val_d;
  logic                    reload_q, reload_d;
  logic [ADDR_WIDTH-1:0]   pc_salvo_q, pc_salvo_d;
  logic [DATA_WIDTH-1:0]   causa_q, causa_d;
  logic [IDX_W-1:0]        win_idx;
  logic                    expire;

  // Scan from the top down so the lowest eligible index is the last one written.
  always_comb begin
    eligible = pend_q & mask_q;
    win_idx  = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      if (eligible[NP-1-i]) win_idx = IDX_W'(NP - 1 - i);
    end
    int_take = (estado_q == OCIOSO) & avanca & (|eligible) & ~reset;
  end

  always_comb begin
    count_d      = count_q;
    reload_d     = reload_q;
    reload_val_d = reload_val_q;
    expire       = 1'b0;
    if (timer_set) begin
      count_d      = timer_value;
      reload_d     = timer_reload;
      reload_val_d = timer_value;
    end else if (avanca && (count_q != '0)) begin
      if (count_q == TIMER_WIDTH'(1)) begin
        expire  = 1'b1;
        count_d = reload_q ? reload_val_q : '0;
      end else begin
        count_d = count_q - TIMER_WIDTH'(1);
      end
    end
  end

  // Clear of the taken bit is applied first so a same-cycle new request keeps it set.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned i = 0; i < NP; i++) begin
      if (int_take && (win_idx == IDX_W'(i))) pend_d[i] = 1'b0;
    end
    pend_d = pend_d | {irq_sync_q & ~irq_prev_q, expire};
  end

  always_comb begin
    estado_d   = estado_q;
    causa_d    = causa_q;
    pc_salvo_d = pc_salvo_q;
    mask_d     = mask_we ? mask_data : mask_q;
    irq_sync_d = irq_in;
    irq_prev_d = irq_sync_q;
    if (ack_cause) causa_d = '0;
    if (int_take) begin
      causa_d    = DATA_WIDTH'(win_idx) + DATA_WIDTH'(1);
      pc_salvo_d = pc_next;
    end
    case (estado_q)
      OCIOSO:  if (int_take) estado_d = SERVICO;
      SERVICO: if (iret)     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= OCIOSO;
      irq_sync_q   <= '0;
      irq_prev_q   <= '0;
      mask_q       <= '1;
      pend_q       <= '0;
      count_q      <= '0;
      reload_q     <= 1'b0;
      reload_val_q <= '0;
      pc_salvo_q   <= '0;
      causa_q      <= '0;
    end else begin
      estado_q     <= estado_d;
      irq_sync_q   <= irq_sync_d;
      irq_prev_q   <= irq_prev_d;
      mask_q       <= mask_d;
      pend_q       <= pend_d;
      count_q      <= count_d;
      reload_q     <= reload_d;
      reload_val_q <= reload_val_d;
      pc_salvo_q   <= pc_salvo_d;
      causa_q      <= causa_d;
    end
  end

  assign int_vector = ADDR_WIDTH'(VECTOR_BASE);
  assign pc_salvo   = pc_salvo_q;
  assign causa      = causa_q;
  assign em_servico = (estado_q == SERVICO);
  assign pendentes  = pend_q;

endmodule

// File: tb/tb_controlador_interrupcoes.sv
// Randomised and directed bench for controlador_interrupcoes with a behavioural
// model and a take scoreboard.
module tb_controlador_interrupcoes;
  localparam int NS = 4;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int TW = 16;
  localparam int VB = 0;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          avanca = 1'b0;
  logic [NS-1:0] irq_in = '0;
  logic          mask_we = 1'b0;
  logic [NS:0]   mask_data = '0;
  logic          timer_set = 1'b0;
  logic [TW-1:0] timer_value = '0;
  logic          timer_reload = 1'b0;
  logic [AW-1:0] pc_next = '0;
  logic          ack_cause = 1'b0;
  logic          iret = 1'b0;
  logic          int_take;
  logic [AW-1:0] int_vector;
  logic [AW-1:0] pc_salvo;
  logic [DW-1:0] causa;
  logic          em_servico;
  logic [NS:0]   pendentes;

  controlador_interrupcoes #(
    .NUM_SOURCES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .TIMER_WIDTH(TW), .VECTOR_BASE(VB)
  ) dut (
    .clock(clock), .reset(reset), .avanca(avanca), .irq_in(irq_in),
    .mask_we(mask_we), .mask_data(mask_data), .timer_set(timer_set),
    .timer_value(timer_value), .timer_reload(timer_reload), .pc_next(pc_next),
    .ack_cause(ack_cause), .iret(iret), .int_take(int_take),
    .int_vector(int_vector), .pc_salvo(pc_salvo), .causa(causa),
    .em_servico(em_servico), .pendentes(pendentes)
  );

  always #5 clock = ~clock;

  typedef struct { int causa; int pc; } take_t;
  take_t sb_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_pend[NS+1];
  bit m_mask[NS+1];
  bit m_irq_s[NS];
  bit m_irq_p[NS];
  int m_count, m_rv, m_causa, m_pc;
  bit m_rel, m_serv;

  function automatic bit model_take(output int w);
    w = -1;
    for (int i = 0; i <= NS; i++) if (w < 0 && m_pend[i] && m_mask[i]) w = i;
    return (!m_serv && avanca && !reset && w >= 0);
  endfunction

  function automatic int model_pend_vec();
    int v = 0;
    for (int i = 0; i <= NS; i++) if (m_pend[i]) v += (1 << i);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model advances on every rising edge using the inputs held during the cycle.
  initial begin : model
    int w;
    bit t;
    forever begin
      @(posedge clock);
      t = model_take(w);
      if (reset) begin
        for (int i = 0; i <= NS; i++) begin m_pend[i] = 0; m_mask[i] = 1; end
        for (int i = 0; i < NS; i++) begin m_irq_s[i] = 0; m_irq_p[i] = 0; end
        m_count = 0; m_rv = 0; m_rel = 0; m_causa = 0; m_pc = 0; m_serv = 0;
      end else begin
        if (t) m_pend[w] = 0;
        for (int i = 0; i < NS; i++) if (m_irq_s[i] && !m_irq_p[i]) m_pend[i+1] = 1;
        if (timer_set) begin
          m_count = int'(timer_value); m_rv = int'(timer_value); m_rel = timer_reload;
        end else if (avanca && m_count > 0) begin
          if (m_count == 1) begin
            m_pend[0] = 1;
            m_count = m_rel ? m_rv : 0;
          end else m_count--;
        end
        for (int i = 0; i < NS; i++) begin m_irq_p[i] = m_irq_s[i]; m_irq_s[i] = irq_in[i]; end
        if (mask_we) for (int i = 0; i <= NS; i++) m_mask[i] = mask_data[i];
        if (ack_cause) m_causa = 0;
        if (t) begin
          m_causa = w + 1; m_pc = int'(pc_next); m_serv = 1;
          sb_q.push_back(take_t'{w + 1, int'(pc_next)});
        end else if (m_serv && iret) m_serv = 0;
      end
    end
  end

  // Monitor: pops one expected take after every observed int_take.
  initial begin : monitor
    int w2;
    bit mt;
    bit chk_take = 0;
    take_t e;
    forever begin
      @(negedge clock);
      if (chk_take) begin
        chk_take = 0;
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL take_unexpected got=1 want=0 t=%0t", $time);
        end else begin
          e = sb_q.pop_front();
          check("take_causa", int'(causa), e.causa);
          check("take_pc", int'(pc_salvo), e.pc);
        end
      end
      mt = model_take(w2);
      check("int_take", int'(int_take), int'(mt));
      check("pendentes", int'(pendentes), model_pend_vec());
      check("em_servico", int'(em_servico), int'(m_serv));
      check("causa", int'(causa), m_causa);
      check("pc_salvo", int'(pc_salvo), m_pc);
      check("int_vector", int'(int_vector), VB);
      if (int_take) chk_take = 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  task automatic pulse_iret();
    iret = 1'b1; tick(1); iret = 1'b0;
  endtask

  task automatic set_timer(input int v, input bit rl);
    timer_set = 1'b1; timer_value = TW'(v); timer_reload = rl;
    tick(1);
    timer_set = 1'b0;
  endtask

  initial begin : stim
    tick(2);
    reset = 1'b0;
    tick(1);

    // one-shot timer, return address 0x040
    avanca = 1'b1; pc_next = 13'h040;
    set_timer(5, 1'b0);
    tick(10);
    pulse_iret();
    tick(10);

    // two simultaneous edges: irq_in[0] first, irq_in[2] after iret
    irq_in = 4'b0101; tick(6);
    pulse_iret(); tick(4);
    pulse_iret(); irq_in = '0; tick(4);

    // masked source stays pending until re-enabled
    mask_we = 1'b1; mask_data = 5'b11101; tick(1); mask_we = 1'b0;
    irq_in[0] = 1'b1; tick(2); irq_in[0] = 1'b0; tick(4);
    mask_we = 1'b1; mask_data = '1; tick(1); mask_we = 1'b0;
    tick(3); pulse_iret(); tick(2);

    // periodic timer with paused core
    set_timer(3, 1'b1);
    for (int i = 0; i < 40; i++) begin
      avanca = (i % 2 == 0);
      iret   = (i % 10 == 9);
      pc_next = AW'(i * 4);
      tick(1);
    end
    iret = 1'b0; avanca = 1'b1;
    set_timer(0, 1'b0); tick(2); pulse_iret(); tick(2);

    // timer expiring on the very cycle its own bit is taken
    set_timer(1, 1'b1);
    for (int i = 0; i < 12; i++) begin iret = (i % 3 == 2); tick(1); end
    iret = 1'b0;
    set_timer(0, 1'b0); tick(2); pulse_iret(); tick(3);

    // iret with a request pending, ack_cause in service, reset in service
    irq_in[1] = 1'b1; tick(4);
    irq_in[2] = 1'b1; tick(3);
    pulse_iret(); tick(2);
    ack_cause = 1'b1; tick(1); ack_cause = 1'b0; tick(1);
    reset = 1'b1; tick(1); reset = 1'b0;
    irq_in = '0; tick(4);
    irq_in[3] = 1'b1; tick(4); pulse_iret(); irq_in = '0; tick(3);

    // random phase
    for (int i = 0; i < 400; i++) begin
      avanca = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) irq_in = irq_in ^ (NS'(1) << $urandom_range(0, NS - 1));
      mask_we      = ($urandom_range(0, 19) == 0);
      mask_data    = (NS + 1)'($urandom);
      timer_set    = ($urandom_range(0, 29) == 0);
      timer_value  = TW'($urandom_range(0, 8));
      timer_reload = 1'($urandom_range(0, 1));
      iret         = ($urandom_range(0, 5) == 0);
      ack_cause    = ($urandom_range(0, 7) == 0);
      reset        = ($urandom_range(0, 99) == 0);
      pc_next      = AW'($urandom);
      tick(1);
    end
    avanca = 1'b0; irq_in = '0; mask_we = 1'b0; timer_set = 1'b0;
    iret = 1'b0; ack_cause = 1'b0; reset = 1'b0;
    tick(5);

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
